// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 keyboard controller: scan-code set 2 decoder and LED command sequencer
// Drains the byte core FIFO into key events and runs ED+arg LED commands with ACK/resend/timeout.
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ps2_rdata,
  input  logic       ps2_dr,
  input  logic       ps2_busy,
  output logic       ps2_rstrb,
  output logic [7:0] ps2_wdata,
  output logic       ps2_wstrb,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  input  logic       led_wr,
  input  logic [2:0] led_state,
  output logic       cmd_busy,
  output logic       cmd_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    C_IDLE,
    C_SEND,
    C_XFER,
    C_WAIT_ACK,
    C_DONE
  } cmd_state_e;

  cmd_state_e    state_q, state_d;
  logic [7:0]    arg_q, arg_d;
  logic          byte_sel_q, byte_sel_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    guard_q, guard_d;
  logic          err_q, err_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wstrb_q, wstrb_d;

  logic       pop_q;
  logic [7:0] byte_q;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic       evt_valid_q, evt_valid_d;
  logic [7:0] evt_code_q, evt_code_d;
  logic       evt_ext_q, evt_ext_d;
  logic       evt_brk_q, evt_brk_d;
  logic       kbd_ack, kbd_nak;

  // pop_q doubles as "byte_q holds a fresh byte" and enforces the one-pop-per-two-cycles spacing
  assign ps2_rstrb = resetn & ps2_dr & ~ps2_busy & ~evt_valid_q & ~pop_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pop_q       <= 1'b0;
      byte_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= 3'd0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
    end else begin
      pop_q       <= ps2_rstrb;
      if (ps2_rstrb) byte_q <= ps2_rdata;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      skip_q      <= skip_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_brk_q   <= evt_brk_d;
    end
  end

  always_comb begin
    skip_d      = skip_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_ext_d   = evt_ext_q;
    evt_brk_d   = evt_brk_q;
    kbd_ack     = 1'b0;
    kbd_nak     = 1'b0;
    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
    if (pop_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (byte_q)
          8'hE1: skip_d = 3'd7;
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'hFA: kbd_ack = (state_q == C_WAIT_ACK);
          8'hFE: kbd_nak = (state_q == C_WAIT_ACK);
          8'hAA, 8'hEE, 8'h00, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            evt_valid_d = 1'b1;
            evt_code_d  = byte_q;
            evt_ext_d   = ext_q;
            evt_brk_d   = brk_q;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= C_IDLE;
      arg_q      <= 8'h00;
      byte_sel_q <= 1'b0;
      retry_q    <= '0;
      tmo_q      <= '0;
      guard_q    <= 2'd0;
      err_q      <= 1'b0;
      wdata_q    <= 8'h00;
      wstrb_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arg_q      <= arg_d;
      byte_sel_q <= byte_sel_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      guard_q    <= guard_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arg_d      = arg_q;
    byte_sel_d = byte_sel_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    guard_d    = guard_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    wstrb_d    = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (led_wr) begin
          arg_d      = {5'b0, led_state};
          byte_sel_d = 1'b0;
          err_d      = 1'b0;
          retry_d    = '0;
          state_d    = C_SEND;
        end
      end
      C_SEND: begin
        if (!ps2_busy) begin
          wdata_d = byte_sel_q ? arg_q : 8'hED;
          wstrb_d = 1'b1;
          guard_d = 2'd2;
          state_d = C_XFER;
        end
      end
      C_XFER: begin
        // core may not raise busy until a cycle or two after the strobe
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else if (!ps2_busy) begin
          tmo_d   = '0;
          state_d = C_WAIT_ACK;
        end
      end
      C_WAIT_ACK: begin
        tmo_d = tmo_q + TW'(1);
        if (kbd_ack) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            retry_d    = '0;
            state_d    = C_SEND;
          end else begin
            state_d = C_DONE;
          end
        end else if (kbd_nak) begin
          if (retry_q < MAX_R) begin
            retry_d = retry_q + RW'(1);
            state_d = C_SEND;
          end else begin
            err_d   = 1'b1;
            state_d = C_DONE;
          end
        end else if (tmo_d == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = C_DONE;
        end
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  assign ps2_wdata = wdata_q;
  assign ps2_wstrb = wstrb_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_ext   = evt_ext_q;
  assign evt_brk   = evt_brk_q;
  assign cmd_busy  = (state_q != C_IDLE);
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - randomized bench for ps2_kbd_ctrl against a byte-level decode model
module tb_ps2_kbd_ctrl;
  localparam int TMO  = 100;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] ps2_rdata;
  logic       ps2_dr, ps2_busy;
  logic       ps2_rstrb;
  logic [7:0] ps2_wdata;
  logic       ps2_wstrb;
  logic       evt_valid, evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext, evt_brk;
  logic       led_wr;
  logic [2:0] led_state;
  logic       cmd_busy, cmd_err;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
    .clk(clk), .resetn(resetn),
    .ps2_rdata(ps2_rdata), .ps2_dr(ps2_dr), .ps2_busy(ps2_busy), .ps2_rstrb(ps2_rstrb),
    .ps2_wdata(ps2_wdata), .ps2_wstrb(ps2_wstrb),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk),
    .led_wr(led_wr), .led_state(led_state), .cmd_busy(cmd_busy), .cmd_err(cmd_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  logic [7:0] core_q[$];
  logic [7:0] sent_q[$];
  logic [9:0] got_q[$];
  int cyc = 0, busy_cnt = 0, busy_len = 4, pops = 0;
  int wstrb_cyc = -1, err_rise_cyc = -1;
  bit prev_err = 0, prev_wstrb = 0;

  // model state: prefix flags, Pause skip, and the event the controller owes us
  bit         m_ext = 0, m_brk = 0, m_valid = 0, m_drop = 0, m_prev_pop = 0, exp_pop;
  int         m_skip = 0, m_due = -1;
  logic [9:0] m_evt = '0, m_pend = '0;

  task automatic decode(input logic [7:0] b);
    if (m_skip != 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hFA || b == 8'hFE) begin
      m_skip = 0;
    end else if (b inside {8'hAA, 8'hEE, 8'h00, 8'hFF}) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      m_pend = {m_ext, m_brk, b};
      m_due  = cyc + 2;
      m_ext  = 0;
      m_brk  = 0;
    end
  endtask

  // core FIFO / keyboard environment plus the per-cycle compare
  always @(negedge clk) begin
    ps2_dr    = (core_q.size() != 0);
    ps2_rdata = ps2_dr ? core_q[0] : 8'h00;
    ps2_busy  = (busy_cnt != 0);
    if (busy_cnt != 0) busy_cnt--;
    #1;
    cyc++;
    if (!resetn) begin
      m_ext = 0; m_brk = 0; m_skip = 0; m_valid = 0; m_drop = 0; m_due = -1;
      m_prev_pop = 0; prev_wstrb = 0; prev_err = 0; busy_cnt = 0;
    end else begin
      if (m_drop) begin
        m_valid = 0;
        m_drop  = 0;
      end
      if (m_due == cyc) begin
        m_valid = 1;
        m_evt   = m_pend;
        m_due   = -1;
      end
      chk("evt_valid", evt_valid, m_valid);
      if (m_valid) chk("evt_fields", {evt_ext, evt_brk, evt_code}, m_evt);
      exp_pop = ps2_dr && !ps2_busy && !m_valid && !m_prev_pop;
      chk("ps2_rstrb", ps2_rstrb, exp_pop);
      if (exp_pop) decode(core_q[0]);
      if (ps2_rstrb && core_q.size() != 0) begin
        void'(core_q.pop_front());
        pops++;
      end
      if (m_valid && evt_ready) begin
        m_drop = 1;
        got_q.push_back(m_evt);
      end
      m_prev_pop = exp_pop;
      if (ps2_wstrb) begin
        chk("wstrb_in_cmd", cmd_busy, 1);
        chk("wstrb_single", prev_wstrb, 0);
        sent_q.push_back(ps2_wdata);
        wstrb_cyc = cyc;
        busy_cnt  = busy_len;
      end
      prev_wstrb = ps2_wstrb;
      if (cmd_err && !prev_err) err_rise_cyc = cyc;
      prev_err = cmd_err;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [9:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 10'h3FF;
  endfunction

  function automatic logic [7:0] sent_at(input int i);
    return (i < sent_q.size()) ? sent_q[i] : 8'hXX;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 13))
      0, 1:    b = 8'hE0;
      2, 3:    b = 8'hF0;
      4:       b = 8'hE1;
      5:       b = 8'hAA;
      6:       b = 8'h00;
      7:       b = 8'hFA;
      8:       b = 8'hFE;
      9:       b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hEE;
      default: b = 8'($urandom_range(1, 8'h83));
    endcase
    return b;
  endfunction

  task automatic drain(input string name);
    int k = 0;
    while ((core_q.size() != 0 || m_valid || m_due >= 0) && k < 500) begin
      step(1);
      k++;
    end
    step(3);
    chk(name, (k < 500), 1);
  endtask

  task automatic wait_sent(input int n, input string name);
    int k = 0;
    while (sent_q.size() < n && k < 400) begin
      step(1);
      k++;
    end
    chk(name, (sent_q.size() >= n), 1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (cmd_busy && k < 400) begin
      step(1);
      k++;
    end
    chk(name, cmd_busy, 0);
  endtask

  task automatic pulse_led(input logic [2:0] st);
    led_state = st;
    led_wr    = 1'b1;
    step(1);
    led_wr    = 1'b0;
  endtask

  int n0;

  initial begin
    resetn = 1'b0; evt_ready = 1'b1; led_wr = 1'b0; led_state = 3'b000;
    core_q.push_back(8'h00);
    step(3);
    chk("rst_rstrb", ps2_rstrb, 0);
    chk("rst_outs", {ps2_wstrb, ps2_wdata, evt_valid, evt_code, evt_ext, evt_brk, cmd_busy, cmd_err}, 0);
    resetn = 1'b1;
    drain("rst_drain");

    // make, break of the same key
    got_q.delete();
    core_q.push_back(8'h1C); core_q.push_back(8'hF0); core_q.push_back(8'h1C);
    drain("t1_drain");
    chk("t1_count", got_q.size(), 2);
    chk("t1_ev0", got_at(0), {2'b00, 8'h1C});
    chk("t1_ev1", got_at(1), {2'b01, 8'h1C});

    // extended break collapses into one event
    got_q.delete();
    core_q.push_back(8'hE0); core_q.push_back(8'hF0); core_q.push_back(8'h75);
    drain("t2_drain");
    chk("t2_count", got_q.size(), 1);
    chk("t2_ev0", got_at(0), {2'b11, 8'h75});

    // backpressure keeps the remaining bytes in the core FIFO
    got_q.delete();
    evt_ready = 1'b0;
    n0 = pops;
    core_q.push_back(8'h15); core_q.push_back(8'h1D); core_q.push_back(8'h24);
    step(30);
    chk("t3_pops", pops - n0, 1);
    chk("t3_dr", ps2_dr, 1);
    chk("t3_valid", evt_valid, 1);
    chk("t3_code", evt_code, 8'h15);
    evt_ready = 1'b1;
    drain("t3_drain");
    chk("t3_count", got_q.size(), 3);
    chk("t3_ev0", got_at(0), {2'b00, 8'h15});
    chk("t3_ev1", got_at(1), {2'b00, 8'h1D});
    chk("t3_ev2", got_at(2), {2'b00, 8'h24});

    // random byte stream with random backpressure
    for (int i = 0; i < 600; i++) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      if (core_q.size() < 3 && $urandom_range(0, 1) != 0) core_q.push_back(rand_byte());
      step(1);
    end
    evt_ready = 1'b1;
    core_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) core_q.push_back(8'hAA);
    drain("rnd_drain");

    // LED update ED 05 with two ACKs
    sent_q.delete();
    busy_len = 4;
    pulse_led(3'b101);
    chk("t5_busy", cmd_busy, 1);
    wait_sent(1, "t5_ed_sent");
    chk("t5_ed", sent_at(0), 8'hED);
    step(12);
    core_q.push_back(8'hFA);
    wait_sent(2, "t5_arg_sent");
    chk("t5_arg", sent_at(1), 8'h05);
    step(12);
    core_q.push_back(8'hFA);
    wait_idle("t5_idle");
    chk("t5_err", cmd_err, 0);
    chk("t5_nsent", sent_q.size(), 2);

    // four resend requests exhaust the retries
    sent_q.delete();
    pulse_led(3'b011);
    for (int i = 0; i < 4; i++) begin
      wait_sent(i + 1, "t6_sent");
      step(12);
      core_q.push_back(8'hFE);
    end
    wait_idle("t6_idle");
    step(20);
    chk("t6_nsent", sent_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6_ed", sent_at(i), 8'hED);
    chk("t6_err", cmd_err, 1);

    // no ACK: two guard cycles, one busy check, then TMO cycles of waiting
    sent_q.delete();
    busy_len = 0;
    err_rise_cyc = -1;
    pulse_led(3'b010);
    chk("t7_err_clr", cmd_err, 0);
    wait_sent(1, "t7_sent");
    wait_idle("t7_idle");
    chk("t7_tmo_cycle", err_rise_cyc - wstrb_cyc, TMO + 3);
    chk("t7_err", cmd_err, 1);
    chk("t7_nsent", sent_q.size(), 1);

    // reset while waiting for the ACK
    sent_q.delete();
    busy_len = 4;
    pulse_led(3'b100);
    wait_sent(1, "t8_sent");
    step(30);
    chk("t8_busy_pre", cmd_busy, 1);
    resetn = 1'b0;
    step(2);
    chk("t8_rst_outs", {ps2_rstrb, ps2_wstrb, ps2_wdata, evt_valid, evt_code, evt_ext, evt_brk, cmd_busy, cmd_err}, 0);
    resetn = 1'b1;
    n0 = sent_q.size();
    step(150);
    chk("t8_no_wstrb", sent_q.size(), n0);
    chk("t8_busy", cmd_busy, 0);
    chk("t8_err", cmd_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
